pong_ball_engine: RTL and testbench
===================================

Name: pong_ball_engine

Overview:
Parametrised ball/score engine for the pong display pipeline, the successor to the fixed 1-D bouncing ball.
- Ball motion is 2-D: it reflects off the top and bottom walls and off either player's paddle.
- Misses are scored per player. A serve/pause/game-over state machine controls play.
- Ball coordinates feed a make_box-style box renderer. Paddle Y positions come from player inputs.

Parameters:
H_RES, 640, visible width in pixels
V_RES, 480, visible height in pixels
COORD_W, 10, width of all coordinate buses
BALL_SIZE, 4, ball width and height in pixels
PADDLE_W, 5, paddle width in pixels
PADDLE_H, 50, paddle height in pixels
P1_X, 0, left edge X of player-1 paddle
P2_X, 635, left edge X of player-2 paddle
TICK_DIV, 500000, pixel_clk cycles per motion tick (>=2)
PAUSE_TICKS, 60, motion ticks spent in SCORED before auto re-serve
SCORE_W, 4, score counter width
WIN_SCORE, 9, score that ends the game (< 2^SCORE_W)

Ports:
pixel_clk  input  1  sole clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
serve  input  1  level; starts play from IDLE or OVER
p1_y  input  COORD_W  top Y of player-1 paddle
p2_y  input  COORD_W  top Y of player-2 paddle
ball_x  output  COORD_W  ball left X
ball_y  output  COORD_W  ball top Y
score1  output  SCORE_W  player-1 score
score2  output  SCORE_W  player-2 score
paddle_hit  output  1  one-cycle pulse on a paddle reflection
point  output  1  one-cycle pulse when a point is scored
game_over  output  1  high while in OVER
playing  output  1  high while in PLAY

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE
  - ball_x=CX=(H_RES-BALL_SIZE)/2 (318 at defaults); ball_y=CY=(V_RES-BALL_SIZE)/2 (238 at defaults)
  - dx=left, dy=down
  - scores=0, tick counter=0, pause counter=0
  - all pulses and flags 0
- Tick: counter runs 0..TICK_DIV-1 and wraps. tick=1 for the single cycle in which the counter equals TICK_DIV-1. The counter free-runs in every state.
- States:
  - IDLE: ball held at centre. serve=1 -> PLAY on the next edge, with dx=left and dy=down.
  - PLAY:
    - On tick, the ball moves exactly 1 px in x and 1 px in y per the dx/dy directions.
    - Registered outputs update on the tick edge (latency 1 cycle from tick).
    - No motion off-tick.
  - SCORED:
    - Ball held at centre. pause counter increments on each tick.
    - After PAUSE_TICKS ticks: pause counter clears and state -> PLAY. dx points toward the player who conceded; dy=down.
  - OVER:
    - game_over=1, ball at centre, scores frozen.
    - serve=1 -> scores cleared, PLAY, dx=left, dy=down.
- Collision evaluation in PLAY, on tick only, using current (pre-move) values. X and Y rules are evaluated independently, so a corner applies both.
  - Top wall: dy=up and ball_y==0 -> dy=down, ball_y=1.
  - Bottom wall: dy=down and ball_y==V_RES-BALL_SIZE -> dy=up, ball_y-1.
  - Paddle overlap test (Y): ball_y+BALL_SIZE > pN_y AND ball_y < pN_y+PADDLE_H. Compute at COORD_W+1 bits, no wrap.
  - Paddle 1: dx=left and ball_x==P1_X+PADDLE_W and overlap with p1 -> dx=right, ball_x+1, paddle_hit=1.
  - Paddle 2: dx=right and ball_x+BALL_SIZE==P2_X and overlap with p2 -> dx=left, ball_x-1, paddle_hit=1.
  - Left miss: dx=left and ball_x==0 -> score2+1, point=1, ball to centre.
  - Right miss: dx=right and ball_x==H_RES-BALL_SIZE -> score1+1, point=1, ball to centre.
  - Miss outcome: if the incremented score equals WIN_SCORE -> OVER, else -> SCORED. Any Y movement on that tick is discarded.
  - Paddle reflection overrides movement in the X axis; the Y rule still applies on the same tick.
- Scores never exceed WIN_SCORE (no wrap). Scores are cleared only by reset or a serve from OVER.
- serve is ignored in PLAY and SCORED.
- paddle_hit and point are registered pulses, each high for exactly one cycle.
- Reset asserted mid-PLAY or mid-SCORED returns everything to reset values immediately, without waiting for a clock edge.

Test Plan:
- Reset, then idle: rst_n=0 then 1, serve=0 for 10 ticks -> ball stays at (318,238); scores 0; playing=0.
- Top wall: TICK_DIV=2; serve; force ball moving up-left so it reaches ball_y=0 -> next tick ball_y=1 with dy down; ball_x keeps decrementing.
- Paddle 1 hit: p1_y=200; ball arrives at ball_x=5 with ball_y=220 moving left -> paddle_hit pulses 1 cycle; ball_x=6 next tick; dx right; scores unchanged.
- Edge-of-paddle miss: p1_y=200, ball_y=250 (ball_y == p1_y+PADDLE_H, no overlap) -> ball passes to ball_x=0. Next tick: score2=1, point pulse, state SCORED, ball at (318,238). After PAUSE_TICKS=3 ticks: PLAY with dx left.
- Corner: ball at (P2_X-BALL_SIZE, 0) moving up-right, p2_y=0 -> the same tick gives dx left, dy down, ball=(630,1) (computed at defaults with P2_X=635), and one paddle_hit.
- Game over: WIN_SCORE=2; player 1 scores twice -> score1=2, game_over=1, ball frozen at centre. Serve asserted -> scores 0,0 and playing=1. Assert rst_n=0 mid-PLAY -> outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/pong_ball_engine.sv
// Ball/score engine for the pong display pipeline: 2-D ball motion with wall and paddle
// reflection, per-player scoring, and an idle/play/scored/over state machine.
module pong_ball_engine #(
  parameter int unsigned H_RES       = 640,
  parameter int unsigned V_RES       = 480,
  parameter int unsigned COORD_W     = 10,
  parameter int unsigned BALL_SIZE   = 4,
  parameter int unsigned PADDLE_W    = 5,
  parameter int unsigned PADDLE_H    = 50,
  parameter int unsigned P1_X        = 0,
  parameter int unsigned P2_X        = 635,
  parameter int unsigned TICK_DIV    = 500000,
  parameter int unsigned PAUSE_TICKS = 60,
  parameter int unsigned SCORE_W     = 4,
  parameter int unsigned WIN_SCORE   = 9
) (
  input  logic               pixel_clk,
  input  logic               rst_n,
  input  logic               serve,
  input  logic [COORD_W-1:0] p1_y,
  input  logic [COORD_W-1:0] p2_y,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               paddle_hit,
  output logic               point,
  output logic               game_over,
  output logic               playing
);

  localparam int unsigned TickW  = $clog2(TICK_DIV);
  localparam int unsigned PauseW = $clog2(PAUSE_TICKS + 1);
  localparam int unsigned ExtW   = COORD_W + 1;

  localparam logic [COORD_W-1:0] CenterX    = COORD_W'((H_RES - BALL_SIZE) / 2);
  localparam logic [COORD_W-1:0] CenterY    = COORD_W'((V_RES - BALL_SIZE) / 2);
  localparam logic [COORD_W-1:0] BottomY    = COORD_W'(V_RES - BALL_SIZE);
  localparam logic [COORD_W-1:0] RightMissX = COORD_W'(H_RES - BALL_SIZE);
  localparam logic [COORD_W-1:0] P1HitX     = COORD_W'(P1_X + PADDLE_W);
  localparam logic [SCORE_W-1:0] WinScore   = SCORE_W'(WIN_SCORE);

  typedef enum logic [1:0] {StIdle, StPlay, StScored, StOver} state_e;

  state_e             r_state, w_state_nxt;
  logic [COORD_W-1:0] r_ball_x, w_ball_x_nxt;
  logic [COORD_W-1:0] r_ball_y, w_ball_y_nxt;
  logic               r_dx, w_dx_nxt;  // 1 = right
  logic               r_dy, w_dy_nxt;  // 1 = down
  logic [SCORE_W-1:0] r_score1, w_score1_nxt;
  logic [SCORE_W-1:0] r_score2, w_score2_nxt;
  logic               r_hit, w_hit_nxt;
  logic               r_point, w_point_nxt;
  logic [PauseW-1:0]  r_pause_cnt, w_pause_nxt;
  logic [TickW-1:0]   r_tick_cnt;

  logic               w_tick;
  logic [COORD_W:0]   w_bx_ext, w_by_ext;
  logic               w_ov1, w_ov2, w_p2_edge;
  logic               w_miss_l, w_miss_r;
  logic [SCORE_W-1:0] w_score1_inc, w_score2_inc;

  assign w_tick = (r_tick_cnt == TickW'(TICK_DIV - 1));

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TickW'(1);
    end
  end

  // Overlap and edge tests are widened by one bit so paddles near the bottom cannot wrap.
  assign w_bx_ext  = {1'b0, r_ball_x};
  assign w_by_ext  = {1'b0, r_ball_y};
  assign w_ov1     = ((w_by_ext + ExtW'(BALL_SIZE)) > {1'b0, p1_y}) &&
                     (w_by_ext < ({1'b0, p1_y} + ExtW'(PADDLE_H)));
  assign w_ov2     = ((w_by_ext + ExtW'(BALL_SIZE)) > {1'b0, p2_y}) &&
                     (w_by_ext < ({1'b0, p2_y} + ExtW'(PADDLE_H)));
  assign w_p2_edge = ((w_bx_ext + ExtW'(BALL_SIZE)) == ExtW'(P2_X));

  assign w_score1_inc = r_score1 + SCORE_W'(1);
  assign w_score2_inc = r_score2 + SCORE_W'(1);

  always_comb begin
    w_state_nxt  = r_state;
    w_ball_x_nxt = r_ball_x;
    w_ball_y_nxt = r_ball_y;
    w_dx_nxt     = r_dx;
    w_dy_nxt     = r_dy;
    w_score1_nxt = r_score1;
    w_score2_nxt = r_score2;
    w_pause_nxt  = r_pause_cnt;
    w_hit_nxt    = 1'b0;
    w_point_nxt  = 1'b0;
    w_miss_l     = 1'b0;
    w_miss_r     = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_ball_x_nxt = CenterX;
        w_ball_y_nxt = CenterY;
        if (serve) begin
          w_state_nxt = StPlay;
          w_dx_nxt    = 1'b0;
          w_dy_nxt    = 1'b1;
        end
      end

      StPlay: begin
        if (w_tick) begin
          if (!r_dy) begin
            if (r_ball_y == '0) begin
              w_dy_nxt     = 1'b1;
              w_ball_y_nxt = COORD_W'(1);
            end else begin
              w_ball_y_nxt = r_ball_y - COORD_W'(1);
            end
          end else if (r_ball_y == BottomY) begin
            w_dy_nxt     = 1'b0;
            w_ball_y_nxt = r_ball_y - COORD_W'(1);
          end else begin
            w_ball_y_nxt = r_ball_y + COORD_W'(1);
          end

          if (!r_dx) begin
            if ((r_ball_x == P1HitX) && w_ov1) begin
              w_dx_nxt     = 1'b1;
              w_ball_x_nxt = r_ball_x + COORD_W'(1);
              w_hit_nxt    = 1'b1;
            end else if (r_ball_x == '0) begin
              w_miss_l = 1'b1;
            end else begin
              w_ball_x_nxt = r_ball_x - COORD_W'(1);
            end
          end else begin
            if (w_p2_edge && w_ov2) begin
              w_dx_nxt     = 1'b0;
              w_ball_x_nxt = r_ball_x - COORD_W'(1);
              w_hit_nxt    = 1'b1;
            end else if (r_ball_x == RightMissX) begin
              w_miss_r = 1'b1;
            end else begin
              w_ball_x_nxt = r_ball_x + COORD_W'(1);
            end
          end

          // A miss keeps dx pointing at the conceding player, ready for the re-serve.
          if (w_miss_l || w_miss_r) begin
            w_ball_x_nxt = CenterX;
            w_ball_y_nxt = CenterY;
            w_dy_nxt     = 1'b1;
            w_point_nxt  = 1'b1;
            w_state_nxt  = StScored;
            if (w_miss_l && (r_score2 < WinScore)) begin
              w_score2_nxt = w_score2_inc;
              if (w_score2_inc == WinScore) w_state_nxt = StOver;
            end
            if (w_miss_r && (r_score1 < WinScore)) begin
              w_score1_nxt = w_score1_inc;
              if (w_score1_inc == WinScore) w_state_nxt = StOver;
            end
          end
        end
      end

      StScored: begin
        w_ball_x_nxt = CenterX;
        w_ball_y_nxt = CenterY;
        if (w_tick) begin
          if (r_pause_cnt == PauseW'(PAUSE_TICKS - 1)) begin
            w_pause_nxt = '0;
            w_state_nxt = StPlay;
            w_dy_nxt    = 1'b1;
          end else begin
            w_pause_nxt = r_pause_cnt + PauseW'(1);
          end
        end
      end

      StOver: begin
        w_ball_x_nxt = CenterX;
        w_ball_y_nxt = CenterY;
        if (serve) begin
          w_score1_nxt = '0;
          w_score2_nxt = '0;
          w_state_nxt  = StPlay;
          w_dx_nxt     = 1'b0;
          w_dy_nxt     = 1'b1;
        end
      end

      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_ball_x    <= CenterX;
      r_ball_y    <= CenterY;
      r_dx        <= 1'b0;
      r_dy        <= 1'b1;
      r_score1    <= '0;
      r_score2    <= '0;
      r_pause_cnt <= '0;
      r_hit       <= 1'b0;
      r_point     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ball_x    <= w_ball_x_nxt;
      r_ball_y    <= w_ball_y_nxt;
      r_dx        <= w_dx_nxt;
      r_dy        <= w_dy_nxt;
      r_score1    <= w_score1_nxt;
      r_score2    <= w_score2_nxt;
      r_pause_cnt <= w_pause_nxt;
      r_hit       <= w_hit_nxt;
      r_point     <= w_point_nxt;
    end
  end

  assign ball_x     = r_ball_x;
  assign ball_y     = r_ball_y;
  assign score1     = r_score1;
  assign score2     = r_score2;
  assign paddle_hit = r_hit;
  assign point      = r_point;
  assign game_over  = (r_state == StOver);
  assign playing    = (r_state == StPlay);

endmodule

// File: tb/tb_pong_ball_engine.sv
// Scoreboard bench for pong_ball_engine on a small 58x48 field with a motion tick every
// second cycle; expected positions are hand-traced along the ball's path.
module tb_pong_ball_engine;

  localparam int CW = 10;
  localparam int SW = 4;

  logic          pixel_clk = 1'b0;
  logic          rst_n     = 1'b0;
  logic          serve     = 1'b0;
  logic [CW-1:0] p1_y, p2_y;
  logic [CW-1:0] ball_x, ball_y;
  logic [SW-1:0] score1, score2;
  logic          paddle_hit, point, game_over, playing;

  always #5 pixel_clk = ~pixel_clk;

  pong_ball_engine #(
    .H_RES(58), .V_RES(48), .COORD_W(CW), .BALL_SIZE(4), .PADDLE_W(5), .PADDLE_H(10),
    .P1_X(0), .P2_X(53), .TICK_DIV(2), .PAUSE_TICKS(3), .SCORE_W(SW), .WIN_SCORE(2)
  ) u_dut (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .serve     (serve),
    .p1_y      (p1_y),
    .p2_y      (p2_y),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .score1    (score1),
    .score2    (score2),
    .paddle_hit(paddle_hit),
    .point     (point),
    .game_over (game_over),
    .playing   (playing)
  );

  int checks   = 0;
  int failures = 0;

  // Independent tick model: with TICK_DIV=2 every second edge after reset is a motion tick.
  logic m_cnt;
  int   tick_no;
  always @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt   <= 1'b0;
      tick_no <= 0;
    end else begin
      m_cnt <= ~m_cnt;
      if (m_cnt) tick_no <= tick_no + 1;
    end
  end

  typedef struct {
    string name;
    int    bx, by, s1, s2;
    int    pl, ov, hit, pt;
  } snap_t;
  typedef struct {
    string name;
    int    is_point;
    int    tick;
  } pulse_t;

  snap_t  snap_q[$];
  pulse_t pulse_q[$];
  event   snap_ev;

  function automatic void cmp(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  task automatic snap(string n, int bx, int by, int s1, int s2, int pl, int ov, int h, int pt);
    snap_t e;
    e.name = n; e.bx = bx; e.by = by; e.s1 = s1; e.s2 = s2;
    e.pl = pl; e.ov = ov; e.hit = h; e.pt = pt;
    snap_q.push_back(e);
    -> snap_ev;
  endtask

  task automatic push_pulse(string n, int is_point, int tick);
    pulse_t p;
    p.name = n; p.is_point = is_point; p.tick = tick;
    pulse_q.push_back(p);
  endtask

  task automatic wait_tick(int target);
    int guard;
    guard = 0;
    while (tick_no < target && guard < 1000) begin
      @(negedge pixel_clk);
      guard++;
    end
    if (tick_no != target) begin
      checks++;
      failures++;
      $display("FAIL wait_tick: reached tick %0d, expected %0d", tick_no, target);
    end
  endtask

  // Snapshot monitor
  initial begin
    snap_t e;
    forever begin
      @(snap_ev);
      while (snap_q.size() > 0) begin
        e = snap_q.pop_front();
        cmp({e.name, ".ball_x"}, int'(ball_x), e.bx);
        cmp({e.name, ".ball_y"}, int'(ball_y), e.by);
        cmp({e.name, ".score1"}, int'(score1), e.s1);
        cmp({e.name, ".score2"}, int'(score2), e.s2);
        cmp({e.name, ".playing"}, int'(playing), e.pl);
        cmp({e.name, ".game_over"}, int'(game_over), e.ov);
        cmp({e.name, ".paddle_hit"}, int'(paddle_hit), e.hit);
        cmp({e.name, ".point"}, int'(point), e.pt);
      end
    end
  end

  // Pulse monitor: every observed pulse must match the next expected one, on the right tick.
  initial begin
    pulse_t p;
    forever begin
      @(negedge pixel_clk);
      if (rst_n === 1'b1 && (paddle_hit === 1'b1 || point === 1'b1)) begin
        if (pulse_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse: hit=%0b point=%0b at tick %0d, expected none",
                   paddle_hit, point, tick_no);
        end else begin
          p = pulse_q.pop_front();
          cmp({p.name, ".point"}, int'(point), p.is_point);
          cmp({p.name, ".hit"}, int'(paddle_hit), 1 - p.is_point);
          cmp({p.name, ".tick"}, tick_no, p.tick);
        end
      end
    end
  end

  initial begin
    int s, s2, s3;
    p1_y = 10'd40;
    p2_y = 10'd0;
    repeat (3) @(negedge pixel_clk);
    snap("reset", 27, 22, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    wait_tick(10);
    snap("idle", 27, 22, 0, 0, 0, 0, 0, 0);

    serve = 1'b1;
    @(negedge pixel_clk);
    serve = 1'b0;
    s = tick_no;
    push_pulse("hit_bl_corner", 0, s + 23);
    push_pulse("hit_tr_corner", 0, s + 67);
    push_pulse("point_left", 1, s + 116);
    push_pulse("hit_p1", 0, s + 142);
    push_pulse("point_right", 1, s + 191);
    push_pulse("point_win", 1, s + 222);
    snap("serve", 27, 22, 0, 0, 1, 0, 0, 0);
    wait_tick(s + 1);   snap("move1", 26, 23, 0, 0, 1, 0, 0, 0);
    wait_tick(s + 22);  snap("pre_p1", 5, 44, 0, 0, 1, 0, 0, 0);
    wait_tick(s + 23);  snap("p1_corner", 6, 43, 0, 0, 1, 0, 1, 0);
    wait_tick(s + 66);  snap("pre_p2", 49, 0, 0, 0, 1, 0, 0, 0);
    wait_tick(s + 67);  snap("p2_corner", 48, 1, 0, 0, 1, 0, 1, 0);
    p1_y = 10'd34;  // ball_y will equal p1_y+PADDLE_H: no overlap
    wait_tick(s + 111); snap("edge_pass", 4, 43, 0, 0, 1, 0, 0, 0);
    wait_tick(s + 115); snap("at_left", 0, 39, 0, 0, 1, 0, 0, 0);
    wait_tick(s + 116); snap("left_miss", 27, 22, 0, 1, 0, 0, 0, 1);
    wait_tick(s + 117);
    serve = 1'b1;
    wait_tick(s + 118); snap("pause", 27, 22, 0, 1, 0, 0, 0, 0);
    wait_tick(s + 119); snap("reserve", 27, 22, 0, 1, 1, 0, 0, 0);
    wait_tick(s + 120); snap("reserve_mv", 26, 23, 0, 1, 1, 0, 0, 0);
    wait_tick(s + 121);
    serve = 1'b0;
    wait_tick(s + 125);
    p1_y = 10'd40;
    p2_y = 10'd10;
    wait_tick(s + 142); snap("p1_hit2", 6, 43, 0, 1, 1, 0, 1, 0);
    wait_tick(s + 186); snap("top_wall", 50, 1, 0, 1, 1, 0, 0, 0);
    wait_tick(s + 191); snap("right_miss", 27, 22, 1, 1, 0, 0, 0, 1);
    wait_tick(s + 194); snap("reserve_r", 27, 22, 1, 1, 1, 0, 0, 0);
    wait_tick(s + 195); snap("move_right", 28, 23, 1, 1, 1, 0, 0, 0);
    wait_tick(s + 217); snap("p2_miss", 50, 43, 1, 1, 1, 0, 0, 0);
    wait_tick(s + 222); snap("win", 27, 22, 2, 1, 0, 1, 0, 1);
    wait_tick(s + 226); snap("over_hold", 27, 22, 2, 1, 0, 1, 0, 0);

    serve = 1'b1;
    @(negedge pixel_clk);
    serve = 1'b0;
    s2 = tick_no;
    snap("over_serve", 27, 22, 0, 0, 1, 0, 0, 0);
    wait_tick(s2 + 5);  snap("replay", 22, 27, 0, 0, 1, 0, 0, 0);

    @(posedge pixel_clk);
    #2 rst_n = 1'b0;
    #1 snap("async_reset", 27, 22, 0, 0, 0, 0, 0, 0);
    @(negedge pixel_clk);
    rst_n = 1'b1;
    serve = 1'b1;
    @(negedge pixel_clk);
    serve = 1'b0;
    s3 = tick_no;
    wait_tick(s3 + 1);  snap("post_reset", 26, 23, 0, 0, 1, 0, 0, 0);

    repeat (2) @(negedge pixel_clk);
    cmp("pulses_pending", pulse_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
